// File: rtl/ram_single_port_if.sv
// Bus bundle for ram_single_port: data, address, strobes and registered read data.
interface ram_single_port_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic [DATA_W-1:0] data_in;
   logic [ADDR_W-1:0] addr;
   logic              rd;
   logic              wr;
   logic              cs;
   logic [DATA_W-1:0] data_out;

   modport master (
      output data_in, addr, rd, wr, cs,
      input  data_out
   );

   modport slave (
      input  data_in, addr, rd, wr, cs,
      output data_out
   );
endinterface

// File: rtl/ram_single_port.sv
// Single-port synchronous RAM with chip select and a registered read port.
// Define RAM_WR_FIRST_EN for write-first behaviour on simultaneous RD/WR (default: read-first).
module ram_single_port #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   ram_single_port_if.slave    bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              in_range_p0;
   logic              rd_en_p0;
   logic              wr_en_p0;
   logic [IDX_W-1:0]  idx_p0;
   logic [DATA_W-1:0] data_out_p1;

   // Stage 0: decode strobes and address range
   assign in_range_p0 = ({1'b0, bus.addr} < DEPTH_CMP);
   assign idx_p0      = bus.addr[IDX_W-1:0];
   assign rd_en_p0    = bus.cs & bus.rd;
   assign wr_en_p0    = bus.cs & bus.wr & in_range_p0;

   // Storage is never reset; an edge seen while reset is held must not write.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en_p0)
         mem[idx_p0] <= bus.data_in;
   end

   // Stage 1: registered read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_p1 <= '0;
      end else if (rd_en_p0) begin
         if (!in_range_p0)
            data_out_p1 <= '0;
`ifdef RAM_WR_FIRST_EN
         else if (bus.wr)
            data_out_p1 <= bus.data_in;
`endif
         else
            data_out_p1 <= mem[idx_p0];
      end
   end

   assign bus.data_out = data_out_p1;

endmodule

// File: tb/tb_ram_single_port.sv
// Directed, table-driven bench for ram_single_port.
module tb_ram_single_port;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   ram_single_port_if #(.DATA_W(16), .ADDR_W(16)) bus ();

   ram_single_port #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct packed {
      logic        cs;
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] din;
      logic        chk;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [32];
   int   nvec;

`ifdef RAM_WR_FIRST_EN
   localparam logic [15:0] RW_EXP = 16'h0022;
`else
   localparam logic [15:0] RW_EXP = 16'h0011;
`endif

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic cs, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [15:0] din);
      bus.cs      = cs;
      bus.rd      = rd;
      bus.wr      = wr;
      bus.addr    = addr;
      bus.data_in = din;
   endtask

   // Apply for one edge, then sample just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic cs, input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [15:0] din, input logic chk, input logic [15:0] exp);
      vecs[nvec] = '{cs, rd, wr, addr, din, chk, exp};
      nvec++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      nvec = 0;
      add(1, 0, 1, 16'd3,     16'h1234, 0, 16'h0000);
      add(1, 1, 0, 16'd3,     16'h0000, 1, 16'h1234);
      add(0, 1, 1, 16'd3,     16'hFFFF, 1, 16'h1234);
      add(0, 1, 0, 16'd5,     16'h0000, 1, 16'h1234);
      add(1, 0, 0, 16'd5,     16'h0000, 1, 16'h1234);
      add(1, 1, 0, 16'd3,     16'h0000, 1, 16'h1234);
      add(1, 0, 1, 16'h0400,  16'hBEEF, 0, 16'h0000);
      add(1, 1, 0, 16'd5,     16'h0000, 1, 16'h000A);
      add(1, 1, 0, 16'h0000,  16'h0000, 1, 16'h0000);
      add(1, 1, 0, 16'd5,     16'h0000, 1, 16'h000A);
      add(1, 1, 0, 16'h0400,  16'h0000, 1, 16'h0000);
      add(1, 1, 0, 16'd200,   16'h0000, 1, 16'h0090);
      add(1, 1, 0, 16'hFFFF,  16'h0000, 1, 16'h0000);
      add(1, 0, 1, 16'd7,     16'h0011, 0, 16'h0000);
      add(1, 1, 0, 16'd7,     16'h0000, 1, 16'h0011);
      add(1, 1, 1, 16'd7,     16'h0022, 1, RW_EXP);
      add(1, 1, 0, 16'd7,     16'h0000, 1, 16'h0022);
      add(1, 0, 1, 16'd7,     16'h0033, 1, 16'h0022);
      add(1, 1, 0, 16'd7,     16'h0000, 1, 16'h0033);
      add(1, 1, 0, 16'd1023,  16'h0000, 1, 16'h00FE);
      add(1, 1, 1, 16'h0400,  16'h5555, 1, 16'h0000);
      add(1, 1, 0, 16'd1023,  16'h0000, 1, 16'h00FE);
      add(1, 1, 0, 16'h0000,  16'h0000, 1, 16'h0000);

      drive(0, 0, 0, 16'h0000, 16'h0000);
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("reset_data_out", bus.data_out, 16'h0000);
      step();
      step();
      check("reset_held", bus.data_out, 16'h0000);
      rst_n = 1'b1;

      for (int k = 0; k < 1024; k++) begin
         drive(1, 0, 1, 16'(k), 16'((2 * k) % 256));
         step();
      end
      for (int k = 0; k < 1024; k++) begin
         drive(1, 1, 0, 16'(k), 16'h0000);
         step();
         check($sformatf("fill_read_%0d", k), bus.data_out, 16'((2 * k) % 256));
      end

      for (int i = 0; i < nvec; i++) begin
         drive(vecs[i].cs, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din);
         step();
         if (vecs[i].chk)
            check($sformatf("vec_%0d", i), bus.data_out, vecs[i].exp);
      end

      // Reset asserted between edges during a read sequence, with a write pending.
      drive(1, 1, 0, 16'd5, 16'h0000);
      step();
      check("pre_reset_read", bus.data_out, 16'h000A);
      drive(1, 1, 1, 16'd10, 16'hDEAD);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_clears", bus.data_out, 16'h0000);
      step();
      check("reset_edge_no_read", bus.data_out, 16'h0000);
      drive(1, 1, 0, 16'd10, 16'h0000);
      #2 rst_n = 1'b1;
      step();
      check("retained_after_reset", bus.data_out, 16'h0014);
      drive(1, 1, 0, 16'd11, 16'h0000);
      step();
      check("read_after_reset_next", bus.data_out, 16'h0016);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
